// File: rtl/led_word_scroller_if.sv
// Word handshake between the ROM reader (master) and the LED scroller (slave).
// word_in is only meaningful while word_valid is high; a word is accepted at a
// rising clock edge where word_valid and word_ready are both high.
interface led_word_scroller_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/led_word_scroller.sv
// Shows 32-bit words on the 8 green LEDs one byte at a time, holding each byte
// for DWELL_CYCLES clocks. The accepting edge loads the first byte, so a word
// takes 4*DWELL_CYCLES cycles to show, followed by one IDLE (accept) cycle.
// Optional build macro LED_SCROLL_BLANK_EN: after the last byte, the LEDs are
// blanked for DWELL_CYCLES more cycles before word_done, and stay dark in IDLE.
module led_word_scroller #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned LSB_FIRST    = 1
) (
  input  logic                clk_in,
  input  logic                reset_n,
  led_word_scroller_if.slave  word_if,
  output logic [7:0]          leds,
  output logic [1:0]          byte_idx,
  output logic                busy,
  output logic                word_done
);

  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [1:0]       FirstIdx = (LSB_FIRST != 0) ? 2'd0 : 2'd3;
  localparam logic [1:0]       LastIdx  = (LSB_FIRST != 0) ? 2'd3 : 2'd0;

`ifdef LED_SCROLL_BLANK_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StShow = 2'd1, StBlank = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StShow = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       leds_q, leds_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             cnt_last;

  function automatic logic [7:0] pick_byte(logic [31:0] w, logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  assign cnt_last           = (cnt_q == CntLast);
  assign word_if.word_ready = (state_q == StIdle);
  assign busy               = (state_q != StIdle);
  assign leds               = leds_q;
  assign byte_idx           = idx_q;
  assign word_done          = done_q;

  // Next-state: accept in IDLE, step bytes on each dwell terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    leds_d  = leds_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (word_if.word_valid) begin
          state_d = StShow;
          cnt_d   = '0;
          word_d  = word_if.word_in;
          idx_d   = FirstIdx;
          leds_d  = pick_byte(word_if.word_in, FirstIdx);
        end
      end
      StShow: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q != LastIdx) begin
            idx_d  = (LSB_FIRST != 0) ? idx_q + 2'd1 : idx_q - 2'd1;
            leds_d = pick_byte(word_q, idx_d);
          end else begin
`ifdef LED_SCROLL_BLANK_EN
            state_d = StBlank;
            leds_d  = 8'h00;
            idx_d   = 2'd0;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef LED_SCROLL_BLANK_EN
      StBlank: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        // Unused encoding: fall back to IDLE without a word_done.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any word in flight.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      leds_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      leds_q  <= leds_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_word_scroller.sv
// Bench for led_word_scroller: three instances (D=4 LSB-first, D=4 MSB-first,
// D=1 LSB-first) driven with randomized valid/word traffic and compared every
// cycle against a timeline model (elapsed cycles since each accept edge).
module tb_led_word_scroller;

`ifdef LED_SCROLL_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  localparam int NDut = 3;
  localparam int DwellTab [NDut] = '{4, 4, 1};
  localparam bit LsbTab   [NDut] = '{1'b1, 1'b0, 1'b1};

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        vld   [NDut];
  logic [31:0] wrd   [NDut];
  logic        rdy   [NDut];
  logic [7:0]  leds  [NDut];
  logic [1:0]  bidx  [NDut];
  logic        busy  [NDut];
  logic        done  [NDut];

  always #5 clk_in = ~clk_in;

  led_word_scroller_if bus0 ();
  led_word_scroller_if bus1 ();
  led_word_scroller_if bus2 ();

  assign bus0.word_valid = vld[0];
  assign bus0.word_in    = wrd[0];
  assign rdy[0]          = bus0.word_ready;
  assign bus1.word_valid = vld[1];
  assign bus1.word_in    = wrd[1];
  assign rdy[1]          = bus1.word_ready;
  assign bus2.word_valid = vld[2];
  assign bus2.word_in    = wrd[2];
  assign rdy[2]          = bus2.word_ready;

  led_word_scroller #(.DWELL_CYCLES(4), .CNT_W(3), .LSB_FIRST(1)) u_lsb (
    .clk_in(clk_in), .reset_n(reset_n), .word_if(bus0),
    .leds(leds[0]), .byte_idx(bidx[0]), .busy(busy[0]), .word_done(done[0])
  );
  led_word_scroller #(.DWELL_CYCLES(4), .CNT_W(3), .LSB_FIRST(0)) u_msb (
    .clk_in(clk_in), .reset_n(reset_n), .word_if(bus1),
    .leds(leds[1]), .byte_idx(bidx[1]), .busy(busy[1]), .word_done(done[1])
  );
  led_word_scroller #(.DWELL_CYCLES(1), .CNT_W(1), .LSB_FIRST(1)) u_d1 (
    .clk_in(clk_in), .reset_n(reset_n), .word_if(bus2),
    .leds(leds[2]), .byte_idx(bidx[2]), .busy(busy[2]), .word_done(done[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: accept edge number and word of the latest accept.
  int          edge_n = 0;
  bit          m_active [NDut];
  int          m_start  [NDut];
  logic [31:0] m_word   [NDut];
  bit          accepted [NDut];
  int          n_sent   [NDut];
  int          n_done_seen [NDut];
  int          n_done_exp  [NDut];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int period(input int i);
    return (Blank ? 5 : 4) * DwellTab[i];
  endfunction

  // Expected outputs for instance i at the current sampling point.
  task automatic expect_now(input int i, output logic [7:0] e_leds, output logic [1:0] e_idx,
                            output logic e_rdy, output logic e_done);
    int el, k;
    e_leds = 8'h00; e_idx = 2'd0; e_rdy = 1'b1; e_done = 1'b0;
    if (m_active[i]) begin
      el = edge_n - m_start[i];
      e_rdy  = (el >= period(i));
      e_done = (el == period(i));
      if (el < 4 * DwellTab[i]) k = el / DwellTab[i];
      else k = 3;
      if (Blank && el >= 4 * DwellTab[i]) begin
        e_leds = 8'h00; e_idx = 2'd0;
      end else begin
        e_idx  = LsbTab[i] ? 2'(k) : 2'(3 - k);
        e_leds = m_word[i][8*e_idx +: 8];
      end
    end
  endtask

  task automatic check_all(input string when);
    logic [7:0] el; logic [1:0] ei; logic er, ed;
    for (int i = 0; i < NDut; i++) begin
      expect_now(i, el, ei, er, ed);
      check($sformatf("%s leds[%0d]", when, i), 32'(leds[i]), 32'(el));
      check($sformatf("%s byte_idx[%0d]", when, i), 32'(bidx[i]), 32'(ei));
      check($sformatf("%s word_ready[%0d]", when, i), 32'(rdy[i]), 32'(er));
      check($sformatf("%s busy[%0d]", when, i), 32'(busy[i]), 32'(!er));
      check($sformatf("%s word_done[%0d]", when, i), 32'(done[i]), 32'(ed));
      if (done[i] === 1'b1) n_done_seen[i]++;
      if (ed) n_done_exp[i]++;
    end
  endtask

  task automatic present(input int i);
    vld[i] = 1'b1;
    if (n_sent[i] == 0)      wrd[i] = 32'hA1B2C3D4;
    else if (n_sent[i] == 1) wrd[i] = 32'h11223344;
    else if (i == 0 && n_sent[i] == 2) wrd[i] = 32'hFFFFFFFF;
    else                     wrd[i] = $urandom;
    n_sent[i]++;
  endtask

  // Model update at each rising edge: accepts only when the model says ready.
  always @(posedge clk_in) begin
    edge_n <= edge_n + 1;
    if (reset_n) begin
      for (int i = 0; i < NDut; i++) begin
        if (vld[i] && (!m_active[i] || (edge_n - m_start[i]) >= period(i))) begin
          m_active[i] <= 1'b1;
          m_start[i]  <= edge_n + 1;
          m_word[i]   <= wrd[i];
          accepted[i] <= 1'b1;
        end
      end
    end
  end

  initial begin
    bit did_reset = 1'b0;
    for (int i = 0; i < NDut; i++) begin
      vld[i] = 1'b0; wrd[i] = '0; m_active[i] = 1'b0; m_start[i] = 0;
      m_word[i] = '0; accepted[i] = 1'b0; n_sent[i] = 0;
      n_done_seen[i] = 0; n_done_exp[i] = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all("reset");
    for (int i = 0; i < NDut; i++) present(i);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk_in);
      #1;
      check_all("run");
      // Mid-run reset, aimed at the last byte (or the blank phase) of instance 0.
      if (!did_reset && cyc > 300 &&
          ((m_active[0] && (edge_n - m_start[0]) == period(0) - 2) || cyc == 1500)) begin
        did_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NDut; i++) begin
          check($sformatf("async reset leds[%0d]", i), 32'(leds[i]), 32'h0);
          check($sformatf("async reset byte_idx[%0d]", i), 32'(bidx[i]), 32'h0);
          check($sformatf("async reset word_ready[%0d]", i), 32'(rdy[i]), 32'h1);
          check($sformatf("async reset busy[%0d]", i), 32'(busy[i]), 32'h0);
          check($sformatf("async reset word_done[%0d]", i), 32'(done[i]), 32'h0);
          m_active[i] = 1'b0;
        end
        @(negedge clk_in);
        #1;
        check_all("in reset");
        reset_n = 1'b1;
      end
      // Driver: hold valid until accepted; first 300 cycles stream back-to-back.
      for (int i = 0; i < NDut; i++) begin
        if (accepted[i]) begin
          accepted[i] = 1'b0;
          vld[i] = 1'b0;
          if (cyc < 300 || $urandom_range(3) == 0) present(i);
          else wrd[i] = $urandom;
        end else if (!vld[i]) begin
          if ($urandom_range(7) == 0) present(i);
          else wrd[i] = $urandom;
        end
      end
    end

    for (int i = 0; i < NDut; i++)
      check($sformatf("word_done count[%0d]", i), 32'(n_done_seen[i]), 32'(n_done_exp[i]));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
